// File: rtl/tis_node_datapath.sv
// rtl/tis_node_datapath.sv - TIS-style node datapath: ACC/BAK registers with handshaked channel ports
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   op_valid/op_ready          operation request / accept (ready only in IDLE)
//   op_code, src_sel, dst_sel  operation fields, captured on accept
//   imm                        immediate operand (used at accept edge only)
//   in_data/in_valid/in_ready  inbound channels, port p at [p*W +: W]
//   out_data/out_valid/out_ready outbound channels, port p at [p*W +: W]
//   acc                        current ACC value
//   op_done                    one-cycle pulse after the completing edge
module tis_node_datapath #(
  parameter int W     = 8,
  parameter int NPORT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op_code,
  input  logic [2:0]           src_sel,
  input  logic [2:0]           dst_sel,
  input  logic [W-1:0]         imm,
  input  logic [NPORT*W-1:0]   in_data,
  input  logic [NPORT-1:0]     in_valid,
  output logic [NPORT-1:0]     in_ready,
  output logic [NPORT*W-1:0]   out_data,
  output logic [NPORT-1:0]     out_valid,
  input  logic [NPORT-1:0]     out_ready,
  output logic [W-1:0]         acc,
  output logic                 op_done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NEG  = 3'd3;
  localparam logic [2:0] OP_SWP  = 3'd4;
  localparam logic [2:0] OP_SAV  = 3'd5;
  localparam logic [2:0] SEL_ACC = 3'd4;
  localparam logic [2:0] SEL_IMM = 3'd5;
  localparam logic [2:0] SEL_ANY = 3'd7;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [2:0]            src_q, src_d;
  logic [2:0]            dst_q, dst_d;
  logic signed [W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]   bak_q, bak_d;
  logic [NPORT*W-1:0]    out_data_q, out_data_d;
  logic                  op_done_q, op_done_d;

  // A port index beyond NPORT is not a port at all; it behaves as NIL.
  function automatic logic is_port(input logic [2:0] sel);
    return (sel == SEL_ANY) || (!sel[2] && (int'(sel[1:0]) < NPORT));
  endfunction

  function automatic logic [NPORT-1:0] port_mask(input logic [2:0] sel);
    logic [NPORT-1:0] m;
    m = '0;
    for (int p = 0; p < NPORT; p++) begin
      if ((sel == SEL_ANY) || (!sel[2] && (int'(sel[1:0]) == p))) m[p] = 1'b1;
    end
    return m;
  endfunction

  // Inputs carry one guard bit; a guard/sign disagreement means overflow.
  function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
    if (x[W] != x[W-1]) begin
      return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return x[W-1:0];
  endfunction

  logic [NPORT-1:0]      in_hit;
  logic [NPORT-1:0]      fin_mask;
  logic signed [W-1:0]   in_word;
  logic signed [W-1:0]   src_val;
  logic signed [W-1:0]   fin_val;
  logic signed [W:0]     acc_x;
  logic signed [W:0]     fin_x;
  logic [2:0]            fin_op;
  logic [2:0]            fin_dst;
  logic                  fin_en;

  assign op_ready  = (state_q == IDLE);
  assign in_ready  = (state_q == READ)  ? port_mask(src_q) : '0;
  assign out_valid = (state_q == WRITE) ? port_mask(dst_q) : '0;
  assign out_data  = out_data_q;
  assign acc       = acc_q;
  assign op_done   = op_done_q;
  assign in_hit    = in_valid & in_ready;

  // Lowest-indexed transferring port wins (matters only for ANY).
  always_comb begin
    in_word = '0;
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (in_hit[p]) in_word = in_data[p*W +: W];
    end
  end

  always_comb begin
    case (src_sel)
      SEL_ACC: src_val = acc_q;
      SEL_IMM: src_val = imm;
      default: src_val = '0;
    endcase
  end

  // The operand value is "finished" either at the accept edge (non-port source)
  // or at the inbound transfer edge; fields come from the inputs or the capture.
  assign fin_val  = (state_q == IDLE) ? src_val : in_word;
  assign fin_op   = (state_q == IDLE) ? op_code : op_q;
  assign fin_dst  = (state_q == IDLE) ? dst_sel : dst_q;
  assign fin_mask = port_mask(fin_dst);
  assign acc_x    = {acc_q[W-1], acc_q};
  assign fin_x    = {fin_val[W-1], fin_val};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    acc_d      = acc_q;
    bak_d      = bak_q;
    out_data_d = out_data_q;
    op_done_d  = 1'b0;
    fin_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d  = op_code;
          src_d = src_sel;
          dst_d = dst_sel;
          case (op_code)
            OP_MOV, OP_ADD, OP_SUB: begin
              if (is_port(src_sel)) state_d = READ;
              else                  fin_en  = 1'b1;
            end
            OP_NEG: begin
              acc_d     = sat(-acc_x);
              op_done_d = 1'b1;
            end
            OP_SWP: begin
              acc_d     = bak_q;
              bak_d     = acc_q;
              op_done_d = 1'b1;
            end
            OP_SAV: begin
              bak_d     = acc_q;
              op_done_d = 1'b1;
            end
            default: op_done_d = 1'b1;
          endcase
        end
      end
      READ: begin
        if (|in_hit) fin_en = 1'b1;
      end
      WRITE: begin
        if (|(out_valid & out_ready)) begin
          op_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_en) begin
      state_d = IDLE;
      case (fin_op)
        OP_ADD: begin
          acc_d     = sat(acc_x + fin_x);
          op_done_d = 1'b1;
        end
        OP_SUB: begin
          acc_d     = sat(acc_x - fin_x);
          op_done_d = 1'b1;
        end
        default: begin
          if (is_port(fin_dst)) begin
            state_d = WRITE;
            for (int p = 0; p < NPORT; p++) begin
              if (fin_mask[p]) out_data_d[p*W +: W] = fin_val;
            end
          end else begin
            if (fin_dst == SEL_ACC) acc_d = fin_val;
            op_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      acc_q      <= '0;
      bak_q      <= '0;
      out_data_q <= '0;
      op_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      acc_q      <= acc_d;
      bak_q      <= bak_d;
      out_data_q <= out_data_d;
      op_done_q  <= op_done_d;
    end
  end

endmodule
